ledger_writer: RTL and testbench

//  Write-side engine for the 1bpp 640x480 background bitmap (480 rows x 20 words of 32 bits).

---
 rtl/ledger_writer_if.sv | 30 +++
 rtl/ledger_writer.sv | 184 ++++++++++++++++++
 tb/tb_ledger_writer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ledger_writer_if.sv
// Command and bitmap-RAM port bundle for ledger_writer.
// The slave modport is the engine; the master modport is the command source plus RAM.
interface ledger_writer_if #(
  parameter int AW = 14
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [9:0]    cmd_x;
  logic [9:0]    cmd_y;
  logic [9:0]    cmd_len;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, mem_rdata,
    input  cmd_ready, busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_len, mem_rdata,
    output cmd_ready, busy, done, err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/ledger_writer.sv
// Span draw engine for a 1bpp 640x480 bitmap: read-modify-write of 32-bit words.
// Optional LEDGER_WRITER_CLEAR_EN enables op 11 as a full-screen clear.
module ledger_writer #(
  parameter int ROWS = 480,
  parameter int COLS = 20,
  parameter int AW   = 14
) (
  input  logic             Clk,
  input  logic             Reset_n,
  ledger_writer_if.slave   bus
);

  localparam logic [10:0]   PIX_W     = 11'(COLS * 32);
  localparam logic [10:0]   ROWS_W    = 11'(ROWS);
  localparam logic [10:0]   PIX_LAST  = 11'(COLS * 32 - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS * COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_WR,
    S_FIN,
    S_CLR
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [1:0]    r_op;
  logic [9:0]    r_x_lo;
  logic [9:0]    r_x_hi;
  logic [4:0]    r_word;
  logic [4:0]    r_word_last;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_err;

  logic          w_accept;
  logic          w_is_clear;
  logic          w_clear_noop;
  logic          w_out_of_range;
  logic          w_cmd_err;
  logic [10:0]   w_x_end_raw;
  logic [9:0]    w_x_end;
  logic [AW-1:0] w_y_ext;
  logic [AW-1:0] w_start_addr;
  logic [4:0]    w_lo_off;
  logic [4:0]    w_hi_off;
  logic [31:0]   w_mask;
  logic [31:0]   w_modified;

  // ---------------- command decode ----------------
  assign w_accept       = bus.cmd_valid && (r_state == S_IDLE);
  assign w_is_clear     = (bus.cmd_op == 2'b11);
  assign w_out_of_range = ({1'b0, bus.cmd_y} >= ROWS_W) || ({1'b0, bus.cmd_x} >= PIX_W);

`ifdef LEDGER_WRITER_CLEAR_EN
  assign w_clear_noop = 1'b0;
`else
  assign w_clear_noop = w_is_clear;
`endif

  assign w_cmd_err = w_clear_noop || (!w_is_clear && w_out_of_range);

  // 11-bit end column so a long span clips at the right edge instead of wrapping
  assign w_x_end_raw  = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_len} - 11'd1;
  assign w_x_end      = (w_x_end_raw > PIX_LAST) ? PIX_LAST[9:0] : w_x_end_raw[9:0];

  assign w_y_ext      = AW'(bus.cmd_y);
  assign w_start_addr = (w_y_ext << 4) + (w_y_ext << 2) + AW'(bus.cmd_x[9:5]);

  // ---------------- per-word mask ----------------
  assign w_lo_off = (r_word == r_x_lo[9:5]) ? r_x_lo[4:0] : 5'd0;
  assign w_hi_off = (r_word == r_word_last) ? r_x_hi[4:0] : 5'd31;

  // bit gi holds the pixel at column offset 31-gi within the word
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_mask
      localparam logic [4:0] OFF = 5'(31 - gi);
      assign w_mask[gi] = (OFF >= w_lo_off) && (OFF <= w_hi_off);
    end
  endgenerate

  always_comb begin
    w_modified = bus.mem_rdata;
    case (r_op)
      2'b00:   w_modified = bus.mem_rdata | w_mask;
      2'b01:   w_modified = bus.mem_rdata & ~w_mask;
      2'b10:   w_modified = bus.mem_rdata ^ w_mask;
      default: w_modified = bus.mem_rdata;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_clear) begin
`ifdef LEDGER_WRITER_CLEAR_EN
            w_state_next = S_CLR;
`else
            w_state_next = S_FIN;
`endif
          end else if (w_out_of_range || (bus.cmd_len == 10'd0)) begin
            w_state_next = S_FIN;
          end else begin
            w_state_next = S_RD;
          end
        end
      end
      S_RD:    w_state_next = S_WT;
      S_WT:    w_state_next = S_WR;
      S_WR:    w_state_next = (r_word == r_word_last) ? S_FIN : S_RD;
      S_CLR:   w_state_next = (r_addr == LAST_ADDR) ? S_FIN : S_CLR;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_op        <= 2'b00;
      r_x_lo      <= '0;
      r_x_hi      <= '0;
      r_word      <= '0;
      r_word_last <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= bus.cmd_op;
            r_x_lo      <= bus.cmd_x;
            r_x_hi      <= w_x_end;
            r_word      <= bus.cmd_x[9:5];
            r_word_last <= w_x_end[9:5];
            r_addr      <= w_is_clear ? '0 : w_start_addr;
            r_wdata     <= '0;
            r_err       <= w_cmd_err;
          end
        end
        // read data is valid during the wait cycle; capture the modified word here
        S_WT: r_wdata <= w_modified;
        S_WR: begin
          if (r_word != r_word_last) begin
            r_word <= r_word + 5'd1;
            r_addr <= r_addr + AW'(1);
          end
        end
        S_CLR: begin
          if (r_addr != LAST_ADDR) begin
            r_addr <= r_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FIN);
  assign bus.err       = (r_state == S_FIN) && r_err;
  assign bus.mem_re    = (r_state == S_RD);
  assign bus.mem_we    = (r_state == S_WR) || (r_state == S_CLR);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_ledger_writer.sv
// Randomized bench for ledger_writer with a pixel-level reference bitmap.
// Define LEDGER_WRITER_CLEAR_EN to exercise the full-screen clear.
`timescale 1ns/1ps
module tb_ledger_writer;
  localparam int ROWS = 480;
  localparam int COLS = 20;
  localparam int AW   = 14;
  localparam int NW   = ROWS * COLS;
  localparam int PIX  = COLS * 32;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  ledger_writer_if #(.AW(AW)) bus();

  ledger_writer #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // bitmap RAM with registered read, plus the reference bitmap
  logic [31:0]   ram     [NW];
  logic [31:0]   ref_ram [NW];
  logic [31:0]   rdata_q = '0;
  logic [31:0]   seed = '0;
  logic          preload = 1'b0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [31:0]   poke_data = '0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  assign bus.mem_rdata = rdata_q;

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ (32'(i) << 7) ^ seed;
  endfunction

  always @(posedge Clk) begin
    if (preload) for (int i = 0; i < NW; i++) ram[i] <= seed_word(i);
    if (poke_en) ram[poke_addr] <= poke_data;
    if (bus.mem_we) begin
      if (int'(bus.mem_addr) < NW) ram[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_re) begin
      if (int'(bus.mem_addr) < NW) rdata_q <= ram[bus.mem_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // pixel-by-pixel reference: walks every column of the clipped span
  task automatic model_cmd(input logic [1:0] op, input int x, input int y, input int len,
                           output int words, output int reads, output logic err, output int lat);
    words = 0; reads = 0; err = 1'b0; lat = 1;
    if (op == 2'b11) begin
`ifdef LEDGER_WRITER_CLEAR_EN
      for (int i = 0; i < NW; i++) ref_ram[i] = '0;
      words = NW;
      lat   = NW + 1;
`else
      err = 1'b1;
`endif
    end else if (y >= ROWS || x >= PIX) begin
      err = 1'b1;
    end else if (len > 0) begin
      int xe;
      xe = x + len - 1;
      if (xe > PIX - 1) xe = PIX - 1;
      for (int c = x; c <= xe; c++) begin
        int idx;
        int b;
        idx = COLS * y + c / 32;
        b   = 31 - (c % 32);
        case (op)
          2'b00:   ref_ram[idx][b] = 1'b1;
          2'b01:   ref_ram[idx][b] = 1'b0;
          default: ref_ram[idx][b] = ~ref_ram[idx][b];
        endcase
      end
      words = xe / 32 - x / 32 + 1;
      reads = words;
      lat   = 3 * words + 1;
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(posedge Clk); #1;
    poke_en = 1'b1; poke_addr = AW'(a); poke_data = d;
    @(posedge Clk); #1;
    poke_en = 1'b0;
    ref_ram[a] = d;
  endtask

  task automatic check_row(input string name, input int y);
    if (y < ROWS) begin
      for (int w = 0; w < COLS; w++) check({name, "_row"}, ram[COLS * y + w], ref_ram[COLS * y + w]);
    end
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input int x, input int y, input int len);
    int words, reads, lat, cyc, rd0, wr0;
    logic err;
    model_cmd(op, x, y, len, words, reads, err, lat);
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op;
    bus.cmd_x = 10'(x); bus.cmd_y = 10'(y); bus.cmd_len = 10'(len);
    cyc = 0;
    while (bus.cmd_ready !== 1'b1 && cyc < 50) begin @(posedge Clk); #1; cyc++; end
    check({name, "_ready_idle"}, bus.cmd_ready, 1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge Clk); #1;
    // keep valid asserted with unrelated fields; nothing may be accepted while busy
    bus.cmd_op  = 2'($urandom_range(0, 2));
    bus.cmd_x   = 10'($urandom_range(0, PIX - 1));
    bus.cmd_y   = 10'($urandom_range(0, ROWS - 1));
    bus.cmd_len = 10'($urandom_range(1, 64));
    cyc = 0;
    do begin @(negedge Clk); cyc++; end while (bus.done !== 1'b1 && cyc < 12000);
    check({name, "_latency"}, cyc, lat);
    check({name, "_err"}, bus.err, err);
    check({name, "_ready_busy"}, bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    check({name, "_reads"}, rd_cnt - rd0, reads);
    check({name, "_writes"}, wr_cnt - wr0, words);
    check_row(name, y);
    $display("cmd %s op=%0d x=%0d y=%0d len=%0d words=%0d cycles=%0d err=%0b",
             name, op, x, y, len, wr_cnt - wr0, cyc, bus.err);
  endtask

  initial begin
    int bad, wr0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_len = '0;
    seed = $urandom;

    // reset state
    #3;
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_re", bus.mem_re, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    preload = 1'b1;
    @(posedge Clk); #1;
    preload = 1'b0;
    for (int i = 0; i < NW; i++) ref_ram[i] = seed_word(i);
    Reset_n = 1'b1;

    // directed spans with known results
    poke(40, 32'h0);
    run_cmd("set_3_2_4", 2'b00, 3, 2, 4);
    check("set_word40", ram[40], 32'h1E00_0000);
    poke(0, 32'h0000_0003);
    poke(1, 32'hFFFF_FFFF);
    run_cmd("tog_30_0_5", 2'b10, 30, 0, 5);
    check("tog_word0", ram[0], 32'h0000_0000);
    check("tog_word1", ram[1], 32'h1FFF_FFFF);
    poke(9599, 32'hFFFF_FFFF);
    poke(9598, 32'hFFFF_FFFF);
    run_cmd("clr_edge", 2'b01, 630, 479, 100);
    check("clr_word9599", ram[9599], 32'hFFFF_FC00);
    check("clr_word9598", ram[9598], 32'hFFFF_FFFF);
    run_cmd("y480", 2'b00, 10, 480, 5);
    run_cmd("x640", 2'b10, 640, 3, 5);
    run_cmd("len0", 2'b00, 10, 7, 0);
    run_cmd("full_row", 2'b10, 0, 100, 1023);

    // randomized spans
    for (int n = 0; n < 60; n++) begin
      int r, x, y, len;
      logic [1:0] op;
      r  = $urandom_range(0, 19);
      op = (r < 6) ? 2'b00 : (r < 12) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      x  = ($urandom_range(0, 9) == 0) ? $urandom_range(PIX, 1023) : $urandom_range(0, PIX - 1);
      y  = ($urandom_range(0, 9) == 0) ? $urandom_range(ROWS, 1023) : $urandom_range(0, ROWS - 1);
      r  = $urandom_range(0, 7);
      len = (r == 0) ? 0 : (r < 5) ? $urandom_range(1, 64) : $urandom_range(0, 1023);
`ifdef LEDGER_WRITER_CLEAR_EN
      if (op == 2'b11) op = 2'b10;
`endif
      run_cmd($sformatf("rnd%0d", n), op, x, y, len);
    end

    // reset while the first word of a two-word span is in flight
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10;
    bus.cmd_x = 10'd20; bus.cmd_y = 10'd5; bus.cmd_len = 10'd30;
    check("mid_ready", bus.cmd_ready, 1);
    wr0 = wr_cnt;
    @(posedge Clk); #1;
    bus.cmd_valid = 1'b0;
    check("mid_rd", bus.mem_re, 1);
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    #2;
    check("mid_rst_we", bus.mem_we, 0);
    check("mid_rst_ready", bus.cmd_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_addr", bus.mem_addr, 0);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    check("mid_ready_after", bus.cmd_ready, 1);
    check("mid_writes", wr_cnt - wr0, 0);
    check_row("mid", 5);
    $display("cmd reset_mid_span x=20 y=5 len=30 writes=%0d", wr_cnt - wr0);

    run_cmd("clear_screen", 2'b11, 0, 0, 0);
    run_cmd("after_clear", 2'b00, 600, 479, 40);

    bad = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== ref_ram[i]) bad++;
    check("ram_final_words_differing", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
